// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared VGA raster timing constants and helpers.
//   - 640x480@60 and 800x600@60 porch/sync widths (pixels for H, lines for V)
//   - vga_ctl_t: the {h_sync, v_sync, blank_n} control bundle that travels
//     through the pixel-aligned delay line
//   - axis_total / sync_start / fits_width: elaboration-time arithmetic
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock, both syncs active-low.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_H_POL    = 1'b0;
  localparam bit VGA640_V_POL    = 1'b0;

  // 800x600 @ 60 Hz, 40 MHz pixel clock, both syncs active-high.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_H_POL    = 1'b1;
  localparam bit SVGA800_V_POL    = 1'b1;

  // Control bundle carried alongside pixel data.
  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic blank_n;
  } vga_ctl_t;

  // Total length of one axis: active + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // First count of the sync pulse (sync follows the front porch).
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction

  // True when 'total' distinct counts fit in a 'width'-bit counter.
  function automatic bit fits_width(input int total, input int width);
    if (width >= 31) return 1'b1;
    return total <= (1 << width);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Enable-qualified shift register: dout is din as it was DEPTH enabled
// clocks earlier. DEPTH=0 is a combinational pass-through.
//   clk    in   system clock
//   reset  in   synchronous active-low reset, loads RESET_VAL into every stage
//   en     in   shift strobe (pixel enable)
//   din    in   WIDTH bits
//   dout   out  WIDTH bits
module vga_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH < 0) begin : g_bad_depth
    $error("vga_delay_line: DEPTH must be >= 0");
  end

  if (DEPTH == 0) begin : g_pass
    // No storage: clock/reset/enable are intentionally unused here.
    logic unused_ok;
    assign unused_ok = ^{clk, reset, en};
    assign dout      = din;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
      if (!reset) begin
        stage <= {DEPTH{RESET_VAL}};
      end else if (en) begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator.
//   clk           in   system clock
//   reset         in   synchronous active-low reset (restarts raster at 0,0)
//   pix_en        out  one-clk pixel strobe every CLK_DIV clocks
//   h_count       out  0..H_TOTAL-1
//   v_count       out  0..V_TOTAL-1
//   h_sync        out  horizontal sync (asserted level H_POL)
//   v_sync        out  vertical sync (asserted level V_POL)
//   blank_n       out  1 inside the active window
//   line_start    out  pix_en at h_count==0
//   frame_start   out  pix_en at (0,0)
//   vblank_start  out  pix_en at h_count==0, v_count==V_ACTIVE
//   h_sync_d      out  h_sync delayed PIPE_DLY pixels
//   v_sync_d      out  v_sync delayed PIPE_DLY pixels
//   blank_n_d     out  blank_n delayed PIPE_DLY pixels
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CNT_W    = 16,
  parameter int H_ACTIVE = VGA640_H_ACTIVE,
  parameter int H_FP     = VGA640_H_FP,
  parameter int H_SYNC   = VGA640_H_SYNC,
  parameter int H_BP     = VGA640_H_BP,
  parameter int V_ACTIVE = VGA640_V_ACTIVE,
  parameter int V_FP     = VGA640_V_FP,
  parameter int V_SYNC   = VGA640_V_SYNC,
  parameter int V_BP     = VGA640_V_BP,
  parameter bit H_POL    = VGA640_H_POL,
  parameter bit V_POL    = VGA640_V_POL,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             h_sync,
  output logic             v_sync,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start,
  output logic             vblank_start,
  output logic             h_sync_d,
  output logic             v_sync_d,
  output logic             blank_n_d
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int H_SS    = sync_start(H_ACTIVE, H_FP);
  localparam int V_SS    = sync_start(V_ACTIVE, V_FP);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if (!fits_width(H_TOTAL, CNT_W) || !fits_width(V_TOTAL, CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 2**CNT_W");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS_C  = CNT_W'(H_SS);
  localparam logic [CNT_W-1:0] H_SE_C  = CNT_W'(H_SS + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS_C  = CNT_W'(V_SS);
  localparam logic [CNT_W-1:0] V_SE_C  = CNT_W'(V_SS + V_SYNC);

  // Reset image of the control bundle. (0,0) is never inside a sync window,
  // so the live bundle resets to its decoded (0,0) value; delayed copies
  // reset to blanked so nothing downstream is drawn before real data arrives.
  localparam vga_ctl_t CTL_RST   = '{h_sync: ~H_POL, v_sync: ~V_POL, blank_n: 1'b1};
  localparam vga_ctl_t CTL_D_RST = '{h_sync: ~H_POL, v_sync: ~V_POL, blank_n: 1'b0};

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  vga_ctl_t         ctl, ctl_nxt, ctl_d;
  logic             at_line_start;

  // Next raster position, used both to advance the counters and to decode
  // sync/blank so the registered decode lines up with the registered counts.
  always_comb begin
    h_nxt = h_count + CNT_ONE;
    v_nxt = v_count;
    if (h_count == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_count == V_LAST) ? '0 : v_count + CNT_ONE;
    end
  end

  always_comb begin
    ctl_nxt         = CTL_RST;
    ctl_nxt.h_sync  = (h_nxt >= H_SS_C && h_nxt < H_SE_C) ? H_POL : ~H_POL;
    ctl_nxt.v_sync  = (v_nxt >= V_SS_C && v_nxt < V_SE_C) ? V_POL : ~V_POL;
    ctl_nxt.blank_n = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
  end

  // The divider treats its reset state as a wrap point, so the first pixel
  // strobe lands on the first clock after reset release and repeats every
  // CLK_DIV clocks. With CLK_DIV=1 div_cnt sits at 0 and pix_en stays high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
      h_count <= '0;
      v_count <= '0;
      ctl     <= CTL_RST;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
      pix_en  <= (div_cnt == '0);
      if (pix_en) begin
        h_count <= h_nxt;
        v_count <= v_nxt;
        ctl     <= ctl_nxt;
      end
    end
  end

  assign h_sync  = ctl.h_sync;
  assign v_sync  = ctl.v_sync;
  assign blank_n = ctl.blank_n;

  // Strobes are gated by reset directly so they drop in the same cycle
  // reset is asserted, not one clock later.
  assign at_line_start = reset && pix_en && (h_count == '0);
  assign line_start    = at_line_start;
  assign frame_start   = at_line_start && (v_count == '0);
  assign vblank_start  = at_line_start && (v_count == V_ACT_C);

  vga_delay_line #(
    .WIDTH    ($bits(vga_ctl_t)),
    .DEPTH    (PIPE_DLY),
    .RESET_VAL(CTL_D_RST)
  ) u_dly (
    .clk  (clk),
    .reset(reset),
    .en   (pix_en),
    .din  (ctl),
    .dout (ctl_d)
  );

  assign h_sync_d  = ctl_d.h_sync;
  assign v_sync_d  = ctl_d.v_sync;
  assign blank_n_d = ctl_d.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pe;
    logic [15:0] h;
    logic [15:0] v;
    logic        hs, vs, bn, ls, fs, vbs, hsd, vsd, bnd;
  } obs_t;

  typedef struct {
    int d, ha, hf, hsw, hb, va, vf, vsw, vb, dly;
    bit hp, vp;
  } cfg_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int k_cyc = 0;   // clocks since the last edge that sampled reset low
  cfg_t cfg [3];
  obs_t obs [3];

  // A: default 640x480, CLK_DIV=2, PIPE_DLY=2
  logic        pe_a, hs_a, vs_a, bn_a, ls_a, fs_a, vbs_a, hsd_a, vsd_a, bnd_a;
  logic [15:0] h_a, v_a;
  vga_timing_gen dut_a (
    .clk(clk), .reset(reset), .pix_en(pe_a), .h_count(h_a), .v_count(v_a),
    .h_sync(hs_a), .v_sync(vs_a), .blank_n(bn_a), .line_start(ls_a),
    .frame_start(fs_a), .vblank_start(vbs_a), .h_sync_d(hsd_a),
    .v_sync_d(vsd_a), .blank_n_d(bnd_a));

  // B: CLK_DIV=3, 28x11 raster, pass-through delay
  logic        pe_b, hs_b, vs_b, bn_b, ls_b, fs_b, vbs_b, hsd_b, vsd_b, bnd_b;
  logic [15:0] h_b, v_b;
  vga_timing_gen #(.CLK_DIV(3), .H_ACTIVE(20), .H_FP(2), .H_SYNC(3), .H_BP(3),
                   .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .PIPE_DLY(0)) dut_b (
    .clk(clk), .reset(reset), .pix_en(pe_b), .h_count(h_b), .v_count(v_b),
    .h_sync(hs_b), .v_sync(vs_b), .blank_n(bn_b), .line_start(ls_b),
    .frame_start(fs_b), .vblank_start(vbs_b), .h_sync_d(hsd_b),
    .v_sync_d(vsd_b), .blank_n_d(bnd_b));

  // C: CLK_DIV=1, 8x4 raster, positive syncs, 4-bit counters, PIPE_DLY=3
  logic       pe_c, hs_c, vs_c, bn_c, ls_c, fs_c, vbs_c, hsd_c, vsd_c, bnd_c;
  logic [3:0] h_c, v_c;
  vga_timing_gen #(.CLK_DIV(1), .CNT_W(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(1), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1),
                   .V_POL(1'b1), .PIPE_DLY(3)) dut_c (
    .clk(clk), .reset(reset), .pix_en(pe_c), .h_count(h_c), .v_count(v_c),
    .h_sync(hs_c), .v_sync(vs_c), .blank_n(bn_c), .line_start(ls_c),
    .frame_start(fs_c), .vblank_start(vbs_c), .h_sync_d(hsd_c),
    .v_sync_d(vsd_c), .blank_n_d(bnd_c));

  assign obs[0] = {pe_a, h_a, v_a, hs_a, vs_a, bn_a, ls_a, fs_a, vbs_a, hsd_a, vsd_a, bnd_a};
  assign obs[1] = {pe_b, h_b, v_b, hs_b, vs_b, bn_b, ls_b, fs_b, vbs_b, hsd_b, vsd_b, bnd_b};
  assign obs[2] = {pe_c, 12'd0, h_c, 12'd0, v_c, hs_c, vs_c, bn_c, ls_c, fs_c, vbs_c,
                   hsd_c, vsd_c, bnd_c};

  function automatic logic lvl(input int c, input int lo, input int len, input bit pol);
    return (c >= lo && c < lo + len) ? pol : !pol;
  endfunction

  // Reference: everything follows from k = clocks since reset release.
  // Pixel strobes occur at k = 1, 1+D, 1+2D, ...; n = pixels already advanced.
  function automatic obs_t model(input cfg_t c, input int k);
    obs_t o;
    int ht, vt, n, h, v, nd, hd, vd;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    o = '0;
    o.pe = (k >= 1) && ((k - 1) % c.d == 0);
    n = (k == 0) ? 0 : (k - 1 + c.d - 1) / c.d;
    h = n % ht;
    v = (n / ht) % vt;
    o.h   = 16'(h);
    o.v   = 16'(v);
    o.hs  = lvl(h, c.ha + c.hf, c.hsw, c.hp);
    o.vs  = lvl(v, c.va + c.vf, c.vsw, c.vp);
    o.bn  = (h < c.ha) && (v < c.va);
    o.ls  = o.pe && (h == 0);
    o.fs  = o.pe && (h == 0) && (v == 0);
    o.vbs = o.pe && (h == 0) && (v == c.va);
    if (n >= c.dly) begin
      nd = n - c.dly;
      hd = nd % ht;
      vd = (nd / ht) % vt;
      o.hsd = lvl(hd, c.ha + c.hf, c.hsw, c.hp);
      o.vsd = lvl(vd, c.va + c.vf, c.vsw, c.vp);
      o.bnd = (hd < c.ha) && (vd < c.va);
    end else begin
      o.hsd = !c.hp;
      o.vsd = !c.vp;
      o.bnd = 1'b0;
    end
    return o;
  endfunction

  task automatic tick();
    logic r;
    r = reset;
    @(posedge clk);
    #1;
    k_cyc = r ? k_cyc + 1 : 0;
  endtask

  task automatic test_reset();
    obs_t e;
    reset = 1'b0;
    repeat (3) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        e = model(cfg[i], k_cyc);
        n_chk++;
        if (obs[i] !== e) $display("FAIL reset_state dut%0d: got %h want %h", i, obs[i], e);
        else n_pass++;
      end
    end
    n_chk++;
    if ({pe_a, h_a, v_a, hs_a, vs_a, bn_a, bnd_a} !== {1'b0, 16'd0, 16'd0, 1'b1, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_a: got pe=%b h=%0d v=%0d hs=%b vs=%b bn=%b bnd=%b want 0 0 0 1 1 1 0",
               pe_a, h_a, v_a, hs_a, vs_a, bn_a, bnd_a);
    else n_pass++;
    n_chk++;
    if ({hs_c, vs_c, hsd_c, vsd_c} !== 4'b0000)
      $display("FAIL reset_pol_c: got hs=%b vs=%b hsd=%b vsd=%b want all 0", hs_c, vs_c, hsd_c, vsd_c);
    else n_pass++;
  endtask

  task automatic test_divider();
    reset = 1'b1;
    repeat (8) begin
      tick();
      n_chk++;
      if (pe_a !== 1'(k_cyc % 2)) $display("FAIL div2_pix_en k=%0d: got %b want %b", k_cyc, pe_a, 1'(k_cyc % 2));
      else n_pass++;
      n_chk++;
      if (pe_c !== 1'b1) $display("FAIL div1_pix_en k=%0d: got %b want 1", k_cyc, pe_c);
      else n_pass++;
      if (k_cyc == 1) begin
        n_chk++;
        if ({h_a, ls_a, fs_a} !== {16'd0, 1'b1, 1'b1})
          $display("FAIL first_pixel: got h=%0d ls=%b fs=%b want 0 1 1", h_a, ls_a, fs_a);
        else n_pass++;
      end
      if (k_cyc == 2) begin
        n_chk++;
        if (h_a !== 16'd1) $display("FAIL h_first_step: got %0d want 1", h_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_hsync_window();
    obs_t e;
    logic p_hs, p_hsd, p_bn;
    logic [15:0] p_h, p_v;
    int falls;
    p_hs = hs_a; p_hsd = hsd_a; p_bn = bn_a; p_h = h_a; p_v = v_a; falls = 0;
    repeat (3300) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        e = model(cfg[i], k_cyc);
        n_chk++;
        if (obs[i] !== e) $display("FAIL run dut%0d k=%0d: got %h want %h", i, k_cyc, obs[i], e);
        else n_pass++;
      end
      if (p_hs && !hs_a) begin
        falls++;
        n_chk++;
        if (h_a !== 16'd656) $display("FAIL hsync_fall: got h=%0d want 656", h_a);
        else n_pass++;
      end
      if (!p_hs && hs_a) begin
        n_chk++;
        if (h_a !== 16'd752) $display("FAIL hsync_rise: got h=%0d want 752", h_a);
        else n_pass++;
      end
      if (p_hsd && !hsd_a) begin
        n_chk++;
        if (h_a !== 16'd658) $display("FAIL hsync_d_fall: got h=%0d want 658", h_a);
        else n_pass++;
      end
      if (!p_hsd && hsd_a) begin
        n_chk++;
        if (h_a !== 16'd754) $display("FAIL hsync_d_rise: got h=%0d want 754", h_a);
        else n_pass++;
      end
      if (p_bn && !bn_a) begin
        n_chk++;
        if (h_a !== 16'd640) $display("FAIL blank_fall: got h=%0d want 640", h_a);
        else n_pass++;
      end
      if (p_h == 16'd799 && h_a != 16'd799) begin
        n_chk++;
        if ({h_a, v_a} !== {16'd0, p_v + 16'd1})
          $display("FAIL h_wrap: got h=%0d v=%0d want 0 %0d", h_a, v_a, p_v + 16'd1);
        else n_pass++;
      end
      n_chk++;
      if ({hsd_b, vsd_b, bnd_b} !== {hs_b, vs_b, bn_b})
        $display("FAIL passthrough: got %b want %b", {hsd_b, vsd_b, bnd_b}, {hs_b, vs_b, bn_b});
      else n_pass++;
      p_hs = hs_a; p_hsd = hsd_a; p_bn = bn_a; p_h = h_a; p_v = v_a;
    end
    n_chk++;
    if (falls < 2) $display("FAIL hsync_edges_seen: got %0d want >=2", falls);
    else n_pass++;
  endtask

  task automatic test_frame();
    obs_t e;
    int pix_b, fr_b, cyc_c, fr_c, run_c, runs_c;
    logic p_hsc, armed;
    logic [15:0] p_vb;
    pix_b = 0; fr_b = 0; cyc_c = 0; fr_c = 0; run_c = 0; runs_c = 0;
    p_hsc = hs_c; armed = 1'b0; p_vb = v_b;
    repeat (2100) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        e = model(cfg[i], k_cyc);
        n_chk++;
        if (obs[i] !== e) $display("FAIL frame_run dut%0d k=%0d: got %h want %h", i, k_cyc, obs[i], e);
        else n_pass++;
      end
      if (pe_b) begin
        if (fs_b) begin
          if (fr_b > 0) begin
            n_chk++;
            if (pix_b !== 308) $display("FAIL frame_b_pixels: got %0d want 308", pix_b);
            else n_pass++;
          end
          fr_b++;
          pix_b = 0;
        end
        pix_b++;
      end
      if (p_vb == 16'd10 && v_b != 16'd10) begin
        n_chk++;
        if (v_b !== 16'd0) $display("FAIL v_wrap_b: got %0d want 0", v_b);
        else n_pass++;
      end
      cyc_c++;
      if (fs_c) begin
        if (fr_c > 0) begin
          n_chk++;
          if (cyc_c !== 32) $display("FAIL frame_c_clocks: got %0d want 32", cyc_c);
          else n_pass++;
        end
        fr_c++;
        cyc_c = 0;
      end
      if (hs_c) run_c++;
      if (p_hsc && !hs_c) begin
        if (armed) begin
          runs_c++;
          n_chk++;
          if (run_c !== 2) $display("FAIL hsync_c_width: got %0d want 2", run_c);
          else n_pass++;
        end
        armed = 1'b1;
        run_c = 0;
      end
      p_hsc = hs_c; p_vb = v_b;
    end
    n_chk++;
    if (fr_b < 2 || fr_c < 2 || runs_c < 2)
      $display("FAIL frames_seen: got b=%0d c=%0d runs=%0d want >=2 each", fr_b, fr_c, runs_c);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    obs_t e;
    int found;
    found = 0;
    for (int t = 0; t < 2000 && found == 0; t++) begin
      tick();
      if (h_a == 16'd300) found = 1;
    end
    n_chk++;
    if (found == 0) $display("FAIL mid_reset_search: got no h=300 want h=300 within 2000 clks");
    else n_pass++;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_chk++;
    if ({h_a, v_a, bn_a, ls_a, fs_a, vbs_a} !== {16'd0, 16'd0, 1'b1, 3'b000})
      $display("FAIL mid_reset: got h=%0d v=%0d bn=%b strobes=%b want 0 0 1 000",
               h_a, v_a, bn_a, {ls_a, fs_a, vbs_a});
    else n_pass++;
    repeat (60) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        e = model(cfg[i], k_cyc);
        n_chk++;
        if (obs[i] !== e) $display("FAIL after_reset dut%0d k=%0d: got %h want %h", i, k_cyc, obs[i], e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int hold, run;
    for (int it = 0; it < 15; it++) begin
      hold = $urandom_range(1, 3);
      run  = $urandom_range(1, 300);
      reset = 1'b0;
      #1;
      n_chk++;
      if ({ls_a, fs_a, vbs_a, ls_b, fs_b, vbs_b, ls_c, fs_c, vbs_c} !== 9'd0)
        $display("FAIL strobe_gate it=%0d: got %b want 0", it,
                 {ls_a, fs_a, vbs_a, ls_b, fs_b, vbs_b, ls_c, fs_c, vbs_c});
      else n_pass++;
      repeat (hold) tick();
      reset = 1'b1;
      repeat (run) begin
        for (int i = 0; i < 3; i++) begin
          e = model(cfg[i], k_cyc);
          n_chk++;
          if (obs[i] !== e) $display("FAIL b2b dut%0d it=%0d k=%0d: got %h want %h", i, it, k_cyc, obs[i], e);
          else n_pass++;
        end
        tick();
      end
    end
  endtask

  initial begin
    cfg[0] = '{d: 2, ha: 640, hf: 16, hsw: 96, hb: 48, va: 480, vf: 10, vsw: 2, vb: 33,
               dly: 2, hp: 1'b0, vp: 1'b0};
    cfg[1] = '{d: 3, ha: 20, hf: 2, hsw: 3, hb: 3, va: 6, vf: 1, vsw: 2, vb: 2,
               dly: 0, hp: 1'b0, vp: 1'b0};
    cfg[2] = '{d: 1, ha: 4, hf: 1, hsw: 2, hb: 1, va: 1, vf: 1, vsw: 1, vb: 1,
               dly: 3, hp: 1'b1, vp: 1'b1};
    test_reset();
    test_divider();
    test_hsync_window();
    test_frame();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
